// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_rr_arbiter
//  Brief    : 8-way round-robin arbiter with a bounded hold time, a one-hot
//             (3-to-8 decoded) grant, a binary grant index and a valid flag.
//             Every output is registered, and each release is followed by at
//             least one idle cycle (break-before-make).
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4      // max consecutive grant cycles, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);

    // Registered state
    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_cnt;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;

    // Next-state values
    state_t     w_state_nxt;
    logic [2:0] w_ptr_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] w_gnt_idx_nxt;
    logic       w_gnt_valid_nxt;

    // Search result
    logic       w_found;
    logic [2:0] w_sel;
    logic [2:0] w_cand;
    logic       w_release;

    // Pick the first requester at or after the pointer, wrapping modulo 8
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        w_cand  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_cand = r_ptr + 3'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Release when the holder drops its request, arbitration is disabled, or
    // the hold budget is used up; simultaneous causes collapse into one release
    assign w_release = !req[r_gnt_idx] || !en || (r_cnt == c_MAX_HOLD);

    // Next-state and next-output logic; registers hold by default
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        case (r_state)
            S_IDLE: begin
                if (en && w_found) begin
                    w_gnt_nxt       = 8'b0000_0001 << w_sel;
                    w_gnt_idx_nxt   = w_sel;
                    w_gnt_valid_nxt = 1'b1;
                    w_cnt_nxt       = 8'd1;
                    w_state_nxt     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    // gnt_idx is kept so it still names the most recent grant
                    w_gnt_nxt       = 8'h00;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 3'd1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_cnt       <= 8'd0;
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_rr_arbiter
//  Brief    : Directed self-checking bench for decoder_rr_arbiter (MAX_HOLD=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_checks = 0;
    int n_errors = 0;

    decoder_rr_arbiter #(.MAX_HOLD(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check all three outputs at once
    task automatic chk_out(input string tag, input logic [7:0] eg,
                           input logic [2:0] ei, input logic ev);
        chk({tag, ".gnt"},   32'(gnt),       32'(eg));
        chk({tag, ".idx"},   32'(gnt_idx),   32'(ei));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(ev));
    endtask

    // Advance one rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected gnt pattern for a single persistent requester with MAX_HOLD=4
    logic [7:0] hold_pat [10] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                                  8'h01, 8'h01, 8'h01, 8'h01, 8'h00};

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        req = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk_out("reset_async", 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        chk_out("reset_held", 8'h00, 3'd0, 1'b0);

        // Post-reset priority from ptr=0
        rst = 1'b0;
        en  = 1'b1;
        req = 8'b1010_0100;
        tick();
        chk_out("prio_first", 8'h04, 3'd2, 1'b1);
        req = 8'h00;
        tick();
        chk_out("prio_release", 8'h00, 3'd2, 1'b0);   // ptr now 3
        tick();
        chk_out("idle_noreq", 8'h00, 3'd2, 1'b0);

        // Hold limit: single persistent requester 0, search wraps from ptr=3
        req = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold_gnt[%0d]", i), 32'(gnt), 32'(hold_pat[i]));
            chk($sformatf("hold_valid[%0d]", i), 32'(gnt_valid), 32'(hold_pat[i] != 8'h00));
        end
        // ptr now 1

        // Round-robin wrap: idx 7 runs out its budget with req 0 also pending
        req = 8'h80;
        tick();
        chk_out("wrap_g7", 8'h80, 3'd7, 1'b1);
        req = 8'h81;
        tick();
        tick();
        tick();
        chk_out("wrap_g7_c4", 8'h80, 3'd7, 1'b1);
        tick();
        chk_out("wrap_gap", 8'h00, 3'd7, 1'b0);       // ptr now 0
        tick();
        chk_out("wrap_g0", 8'h01, 3'd0, 1'b1);
        req = 8'h80;
        tick();
        chk_out("wrap_rel0", 8'h00, 3'd0, 1'b0);      // ptr now 1
        tick();
        chk_out("wrap_g7b", 8'h80, 3'd7, 1'b1);
        req = 8'h00;
        tick();
        chk_out("wrap_rel7", 8'h00, 3'd7, 1'b0);      // ptr now 0

        // Early release of idx 3, with idx 5 arriving mid-grant
        req = 8'h08;
        tick();
        chk_out("early_g3", 8'h08, 3'd3, 1'b1);
        req = 8'h28;
        tick();
        chk_out("early_ignore5", 8'h08, 3'd3, 1'b1);
        req = 8'h20;
        tick();
        chk_out("early_rel", 8'h00, 3'd3, 1'b0);      // ptr now 4
        tick();
        chk_out("early_g5", 8'h20, 3'd5, 1'b1);

        // Disable during grant releases on that edge; idle with en=0 holds
        en = 1'b0;
        tick();
        chk_out("dis_rel", 8'h00, 3'd5, 1'b0);        // ptr now 6
        req = 8'hFF;
        tick();
        chk_out("dis_idle", 8'h00, 3'd5, 1'b0);

        // Reset mid-grant drops gnt without a clock edge
        en = 1'b1;
        tick();
        chk_out("rst_pre_g6", 8'h40, 3'd6, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_out("rst_mid", 8'h00, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_out("rst_after_g0", 8'h01, 3'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
